// File: rtl/frog_hit_ctrl.sv
// Per-frame frog/car collision scan with life, death-freeze and respawn control; optional grace period under FROG_INVULN_EN.
// Latency: car k compared in cycle T+1+k after the frame pulse at edge T; o_Hit/o_Lives/o_Freeze update at edge T+N_CARS+1.
// Backpressure: none; frame pulses arriving during SCAN are dropped, i_Restart overrides everything.
module frog_hit_ctrl #(
    parameter int N_CARS       = 4,
    parameter int TILE_SIZE    = 32,
    parameter int LANE0_Y      = 64,
    parameter int START_LIVES  = 3,
    parameter int DEATH_FRAMES = 30,
    parameter int GRACE_FRAMES = 60
) (
    input  logic                                       i_Clk,
    input  logic                                       i_Rst_n,
    input  logic                                       i_Frame_Start,
    input  logic                                       i_Restart,
    input  logic [9:0]                                 i_Frog_X,
    input  logic [8:0]                                 i_Frog_Y,
    input  logic [10*N_CARS-1:0]                       i_Car_X,
    output logic                                       o_Hit,
    output logic [((N_CARS > 1) ? $clog2(N_CARS) : 1)-1:0] o_Hit_Idx,
    output logic [2:0]                                 o_Lives,
    output logic                                       o_Freeze,
    output logic                                       o_Respawn,
    output logic                                       o_Game_Over,
    output logic                                       o_Invuln
);
    localparam int IW = (N_CARS > 1) ? $clog2(N_CARS) : 1;
    localparam int SW = $clog2(N_CARS + 1);
    localparam int DW = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEAD, S_OVER} state_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        scan_idx;
    logic [IW-1:0]        cur_idx;
    logic [9:0]           frog_x_snap;
    logic [8:0]           frog_y_snap;
    logic [10*N_CARS-1:0] car_snap;
    logic [9:0]           car_cur;
    logic [9:0]           lane_y;
    logic                 hit_flag;
    logic                 ovl;
    logic [DW-1:0]        death_cnt;
    logic                 go_scan, do_hit, do_respawn, do_restart;

    assign cur_idx = scan_idx[IW-1:0];
    assign car_cur = (scan_idx < SW'(N_CARS)) ? car_snap[10*cur_idx +: 10] : 10'd0;
    assign lane_y  = 10'(LANE0_Y + 32'(cur_idx) * TILE_SIZE);

    // Widened sums so edge cases near the right/bottom border never wrap.
    always_comb begin
        ovl = ({1'b0, frog_x_snap} < ({1'b0, car_cur} + 11'(TILE_SIZE))) &&
              (({1'b0, frog_x_snap} + 11'(TILE_SIZE)) > {1'b0, car_cur}) &&
              ({1'b0, frog_y_snap} >= lane_y) &&
              ({1'b0, frog_y_snap} < (lane_y + 10'(TILE_SIZE)));
    end

    always_comb begin
        state_nxt  = state;
        go_scan    = 1'b0;
        do_hit     = 1'b0;
        do_respawn = 1'b0;
        do_restart = 1'b0;
        if (i_Restart) begin
            state_nxt  = S_IDLE;
            do_restart = 1'b1;
        end else begin
            case (state)
                S_IDLE: if (i_Frame_Start) begin
                    state_nxt = S_SCAN;
                    go_scan   = 1'b1;
                end
                S_SCAN: if (scan_idx == SW'(N_CARS)) begin
                    if (hit_flag && !o_Invuln) begin
                        state_nxt = S_DEAD;
                        do_hit    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_DEAD: if (i_Frame_Start && death_cnt <= DW'(1)) begin
                    if (o_Lives == 3'd0) begin
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt  = S_IDLE;
                        do_respawn = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scan_idx    <= '0;
            frog_x_snap <= '0;
            frog_y_snap <= '0;
            car_snap    <= '0;
            hit_flag    <= 1'b0;
            death_cnt   <= '0;
            o_Hit       <= 1'b0;
            o_Hit_Idx   <= '0;
            o_Lives     <= 3'(START_LIVES);
            o_Freeze    <= 1'b0;
            o_Respawn   <= 1'b0;
            o_Game_Over <= 1'b0;
        end else begin
            o_Hit     <= do_hit;
            o_Respawn <= do_respawn | do_restart;
            if (do_restart) begin
                o_Lives     <= 3'(START_LIVES);
                hit_flag    <= 1'b0;
                scan_idx    <= '0;
                death_cnt   <= '0;
                o_Freeze    <= 1'b0;
                o_Game_Over <= 1'b0;
            end else begin
                if (go_scan) begin
                    frog_x_snap <= i_Frog_X;
                    frog_y_snap <= i_Frog_Y;
                    car_snap    <= i_Car_X;
                    hit_flag    <= 1'b0;
                    scan_idx    <= '0;
                end
                if (state == S_SCAN && scan_idx < SW'(N_CARS)) begin
                    scan_idx <= scan_idx + 1'b1;
                    if (ovl && !hit_flag) begin
                        hit_flag  <= 1'b1;
                        o_Hit_Idx <= cur_idx;
                    end
                end
                if (do_hit) begin
                    o_Lives   <= o_Lives - 3'd1;
                    death_cnt <= DW'(DEATH_FRAMES);
                    o_Freeze  <= 1'b1;
                end
                if (state == S_DEAD && i_Frame_Start && death_cnt != '0) begin
                    death_cnt <= death_cnt - 1'b1;
                end
                if (do_respawn) begin
                    o_Freeze <= 1'b0;
                end
                if (state_nxt == S_OVER) begin
                    o_Game_Over <= 1'b1;
                    o_Freeze    <= 1'b1;
                end
            end
        end
    end

`ifdef FROG_INVULN_EN
    localparam int GW = $clog2(GRACE_FRAMES + 1);
    logic [GW-1:0] grace_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            grace_cnt <= '0;
            o_Invuln  <= 1'b0;
        end else if (do_respawn || do_restart) begin
            grace_cnt <= GW'(GRACE_FRAMES);
            o_Invuln  <= (GRACE_FRAMES != 0);
        end else if (state == S_IDLE && i_Frame_Start && grace_cnt != '0) begin
            grace_cnt <= grace_cnt - 1'b1;
            o_Invuln  <= (grace_cnt > GW'(1));
        end
    end
`else
    localparam int unused_grace = GRACE_FRAMES;
    assign o_Invuln = 1'b0;
`endif

endmodule

// File: tb/tb_frog_hit_ctrl.sv
// Directed bench for frog_hit_ctrl: hit timing, edge-touch boundaries, game over, restart and async reset.
module tb_frog_hit_ctrl;
    localparam int N_CARS = 4;
    localparam int DEATH  = 30;
    localparam int GRACE  = 60;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_Frame_Start = 1'b0;
    logic        i_Restart = 1'b0;
    logic [9:0]  i_Frog_X = '0;
    logic [8:0]  i_Frog_Y = '0;
    logic [39:0] i_Car_X = '0;
    logic        o_Hit;
    logic [1:0]  o_Hit_Idx;
    logic [2:0]  o_Lives;
    logic        o_Freeze;
    logic        o_Respawn;
    logic        o_Game_Over;
    logic        o_Invuln;

    int n_tests = 0;
    int n_fail  = 0;
    int hit_cnt = 0;
    int resp_cnt = 0;
    int h0, r0;

    frog_hit_ctrl #(.N_CARS(N_CARS), .TILE_SIZE(32), .LANE0_Y(64), .START_LIVES(3),
                    .DEATH_FRAMES(DEATH), .GRACE_FRAMES(GRACE)) u_dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Frame_Start(i_Frame_Start), .i_Restart(i_Restart),
        .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y), .i_Car_X(i_Car_X),
        .o_Hit(o_Hit), .o_Hit_Idx(o_Hit_Idx), .o_Lives(o_Lives), .o_Freeze(o_Freeze),
        .o_Respawn(o_Respawn), .o_Game_Over(o_Game_Over), .o_Invuln(o_Invuln)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) begin
        if (o_Hit) hit_cnt++;
        if (o_Respawn) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_scene(input int fx, input int fy, input int car_idx, input int cx);
        i_Frog_X = 10'(fx);
        i_Frog_Y = 9'(fy);
        for (int k = 0; k < N_CARS; k++) i_Car_X[10*k +: 10] = 10'd700;
        i_Car_X[10*car_idx +: 10] = 10'(cx);
    endtask

    // One-cycle frame pulse, then enough idle cycles for a full scan to finish.
    task automatic frame();
        @(negedge i_Clk) i_Frame_Start = 1'b1;
        @(negedge i_Clk) i_Frame_Start = 1'b0;
        repeat (7) @(negedge i_Clk);
    endtask

    // Deliver DEATH frame pulses; returns at the negedge after the consuming edge.
    task automatic death_frames();
        repeat (DEATH - 1) frame();
        @(negedge i_Clk) i_Frame_Start = 1'b1;
        @(negedge i_Clk) i_Frame_Start = 1'b0;
    endtask

    task automatic burn_grace();
`ifdef FROG_INVULN_EN
        logic [8:0] sy;
        sy = i_Frog_Y;
        i_Frog_Y = 9'd0;
        repeat (GRACE) frame();
        i_Frog_Y = sy;
`endif
    endtask

    initial begin
        set_scene(0, 0, 0, 700);
        #12;
        check("reset_lives", o_Lives, 3);
        check("reset_hit", o_Hit, 0);
        check("reset_idx", o_Hit_Idx, 0);
        check("reset_freeze", o_Freeze, 0);
        check("reset_respawn", o_Respawn, 0);
        check("reset_gameover", o_Game_Over, 0);
        check("reset_invuln", o_Invuln, 0);
        @(negedge i_Clk) i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Hit 1: frog (100,96) in lane 1, car1 at X=90; check exact latency.
        set_scene(100, 96, 1, 90);
        @(negedge i_Clk) i_Frame_Start = 1'b1;
        @(negedge i_Clk) i_Frame_Start = 1'b0;
        repeat (4) @(posedge i_Clk);
        #1 check("hit_not_early", o_Hit, 0);
        check("lives_not_early", o_Lives, 3);
        @(posedge i_Clk);
        #1 check("hit1_pulse", o_Hit, 1);
        check("hit1_idx", o_Hit_Idx, 1);
        check("hit1_lives", o_Lives, 2);
        check("hit1_freeze", o_Freeze, 1);
        @(posedge i_Clk);
        #1 check("hit1_one_cycle", o_Hit, 0);
        r0 = resp_cnt;
        death_frames();
        check("dead1_respawn", o_Respawn, 1);
        check("dead1_unfreeze", o_Freeze, 0);
        @(negedge i_Clk) check("dead1_respawn_once", o_Respawn, 0);
        burn_grace();

        // Edges exactly touching on either side must not collide.
        h0 = hit_cnt;
        set_scene(132, 96, 1, 100);
        frame();
        set_scene(68, 96, 1, 100);
        frame();
        check("touch_no_hit", hit_cnt - h0, 0);
        check("touch_lives", o_Lives, 2);
        check("touch_freeze", o_Freeze, 0);

        // One pixel of overlap collides.
        set_scene(131, 96, 1, 100);
        frame();
        check("overlap_hit", hit_cnt - h0, 1);
        check("overlap_lives", o_Lives, 1);
        death_frames();
        check("dead2_respawn", o_Respawn, 1);
        burn_grace();

        // Hit 3 on lane 3, then game over with no respawn.
        h0 = hit_cnt;
        set_scene(200, 160, 3, 190);
        frame();
        check("hit3_count", hit_cnt - h0, 1);
        check("hit3_idx", o_Hit_Idx, 3);
        check("hit3_lives", o_Lives, 0);
        r0 = resp_cnt;
        death_frames();
        check("over_flag", o_Game_Over, 1);
        check("over_freeze", o_Freeze, 1);
        check("over_lives", o_Lives, 0);
        check("over_no_respawn", o_Respawn, 0);
        repeat (3) frame();
        check("over_respawn_cnt", resp_cnt - r0, 0);
        check("over_frames_noop", hit_cnt - h0, 1);
        check("over_stays", o_Game_Over, 1);

        // Restart out of game over.
        @(negedge i_Clk) i_Restart = 1'b1;
        @(negedge i_Clk) i_Restart = 1'b0;
        check("restart_respawn", o_Respawn, 1);
        check("restart_lives", o_Lives, 3);
        check("restart_gameover", o_Game_Over, 0);
        check("restart_freeze", o_Freeze, 0);
        repeat (2) @(negedge i_Clk);
        burn_grace();

        // Restart + frame pulse together mid-scan of a colliding frog.
        h0 = hit_cnt;
        set_scene(100, 96, 1, 90);
        @(negedge i_Clk) i_Frame_Start = 1'b1;
        @(negedge i_Clk) i_Frame_Start = 1'b0;
        @(negedge i_Clk) begin i_Restart = 1'b1; i_Frame_Start = 1'b1; end
        @(negedge i_Clk) begin i_Restart = 1'b0; i_Frame_Start = 1'b0; end
        check("midscan_respawn", o_Respawn, 1);
        check("midscan_lives", o_Lives, 3);
        repeat (8) @(negedge i_Clk);
        check("midscan_no_hit", hit_cnt - h0, 0);
        check("midscan_freeze", o_Freeze, 0);
        burn_grace();

        // Back in IDLE: the next frame scans and hits.
        frame();
        check("post_restart_hit", hit_cnt - h0, 1);
        check("post_restart_lives", o_Lives, 2);

        // Async reset while DEAD.
        @(negedge i_Clk);
        #2 i_Rst_n = 1'b0;
        #1;
        check("arst_lives", o_Lives, 3);
        check("arst_freeze", o_Freeze, 0);
        check("arst_idx", o_Hit_Idx, 0);
        check("arst_hit", o_Hit, 0);
        check("arst_respawn", o_Respawn, 0);
        check("arst_gameover", o_Game_Over, 0);
        @(negedge i_Clk) i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);
        check("arst_idle_no_hit", o_Freeze, 0);

`ifdef FROG_INVULN_EN
        // Grace after restart: collisions suppressed until the 60th frame.
        @(negedge i_Clk) i_Restart = 1'b1;
        @(negedge i_Clk) i_Restart = 1'b0;
        check("grace_on", o_Invuln, 1);
        h0 = hit_cnt;
        set_scene(100, 0, 1, 90);
        repeat (10) frame();
        set_scene(100, 96, 1, 90);
        frame();
        check("grace_no_hit", hit_cnt - h0, 0);
        check("grace_lives", o_Lives, 3);
        check("grace_invuln", o_Invuln, 1);
        check("grace_idx", o_Hit_Idx, 1);
        repeat (48) frame();
        check("grace_still_safe", hit_cnt - h0, 0);
        frame();
        check("grace_expired_hit", hit_cnt - h0, 1);
        check("grace_expired_inv", o_Invuln, 0);
        check("grace_expired_lives", o_Lives, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frog_hit_ctrl.md
# frog_hit_ctrl

Per-frame collision scheduler and life controller for the frogger play field. Once per video frame it snapshots the frog position and sequentially tests it against every lane car with a single shared overlap comparator. On a hit it freezes play, decrements lives, and times the death animation. It then issues a respawn or enters game-over. Sits between the VGA sync generator (frame pulse), the car movers, and the frog movement / display logic.

## Interface
- N_CARS, 4 — number of cars, one per lane; car k lives in lane k
- TILE_SIZE, 32 — square sprite size in pixels, frog and cars
- LANE0_Y, 64 — top-left Y of lane 0; lane k Y = LANE0_Y + k*TILE_SIZE
- START_LIVES, 3 — lives after reset/restart (1..7)
- DEATH_FRAMES, 30 — frames frozen after a hit (>=1)
- GRACE_FRAMES, 60 — invulnerable frames after respawn (INVULN_EN only)

- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Frame_Start  in  1  one-cycle pulse at start of vertical blank
- i_Restart  in  1  one-cycle pulse, start new game
- i_Frog_X  in  10  frog top-left X
- i_Frog_Y  in  9  frog top-left Y
- i_Car_X  in  10*N_CARS  packed car top-left X, car k at bits [10k+9:10k]
- o_Hit  out  1  one-cycle pulse: collision registered, life lost
- o_Hit_Idx  out  clog2(N_CARS)  lowest-index car hit in last scan
- o_Lives  out  3  remaining lives
- o_Freeze  out  1  high while dead or game over; movers hold position
- o_Respawn  out  1  one-cycle pulse: frog must return to start tile
- o_Game_Over  out  1  level, high in GAME_OVER
- o_Invuln  out  1  high during grace period (0 when INVULN_EN undefined)

## Operation
- States: IDLE, SCAN, DEAD, GAME_OVER.
- IDLE: on i_Frame_Start, latch i_Frog_X/Y and i_Car_X into snapshot regs, clear hit flag, index=0, go SCAN.
- SCAN: one car per cycle, index 0..N_CARS-1. Overlap when frog_x < car_x+TILE_SIZE and frog_x+TILE_SIZE > car_x and frog_y >= lane_y and frog_y < lane_y+TILE_SIZE. Strict on both X edges, so touching edges do not collide. All sums are computed 11-bit (X) / 10-bit (Y), with no wrap. First hit sets flag and latches o_Hit_Idx; later hits do not overwrite it.
- End of SCAN with flag set and not invulnerable: o_Hit pulse, lives-1, freeze counter=DEATH_FRAMES, go DEAD. Otherwise go IDLE.
- DEAD: each i_Frame_Start decrements the counter. When it reaches 0: if lives==0 go GAME_OVER; else pulse o_Respawn and go IDLE.
- GAME_OVER: o_Game_Over=1, o_Freeze=1. Frame pulses are ignored.
- i_Restart in any state, including mid-SCAN: lives=START_LIVES, flag cleared, o_Respawn pulse, go IDLE next cycle. Restart beats a simultaneous i_Frame_Start; that frame is not scanned.
- i_Frame_Start while in SCAN is ignored; no queuing.
- Lives never underflow; a hit is impossible with lives==0 since GAME_OVER does not scan.

## Timing
- Reset values: state IDLE, o_Lives=START_LIVES, o_Hit_Idx=0, o_Hit=0, o_Respawn=0, o_Freeze=0, o_Game_Over=0, o_Invuln=0, counters 0.
- i_Frame_Start sampled at edge T. Car k is compared during cycle T+1+k.
- o_Hit and the new o_Lives are valid at edge T+N_CARS+1. o_Freeze rises at that same edge.
- o_Respawn is high for the one cycle after the edge that consumed the DEATH_FRAMES-th frame pulse. o_Freeze falls on the same edge.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- FROG_INVULN_EN defined: o_Respawn (death or restart) loads grace counter=GRACE_FRAMES and raises o_Invuln. Each i_Frame_Start in IDLE decrements the counter; o_Invuln drops at 0. Scans still run and latch o_Hit_Idx, but o_Hit, life loss and DEAD are suppressed.
- Undefined: no grace counter, o_Invuln tied 0, every scored hit is lethal.

## Test plan
- Frog (100,96), car1 X=90, LANE0_Y=64 -> o_Hit at T+5, o_Hit_Idx=1, o_Lives 3->2, o_Freeze=1.
- Frog X=132, car X=100 (edges touch) -> no o_Hit; X=131 -> o_Hit.
- Three hits each followed by DEATH_FRAMES frame pulses -> o_Game_Over=1, o_Lives=0, no o_Respawn after third; subsequent frames are no-ops.
- i_Restart together with i_Frame_Start during SCAN of a colliding frog -> no o_Hit, o_Lives=3, o_Respawn pulse, IDLE.
- FROG_INVULN_EN: hit at grace frame 10 -> no o_Hit, lives unchanged, o_Invuln=1; same overlap after 60 frames -> o_Hit.
- Async reset asserted mid-DEAD -> all outputs at reset values immediately, o_Lives=3.
